systolic_ctrl: RTL and testbench

Sequencing controller for an N×N output-stationary systolic array of 8-bit multiply-accumulate PEs. On each start it clears the array accumulators, streams matrix A (west edge) and matrix B (north edge) from two operand buffers with the diagonal skew the mesh requires, and flushes the pipeline with zeros. It signals done once every PE holds its final C[i][j] = Σk A[i][k]·B[k][j]. It sits between the operand buffers and the PE mesh; result readout is outside this block.

---
 rtl/npu_pkg.sv | 20 ++
 rtl/skew_line.sv | 26 ++
 rtl/systolic_ctrl.sv | 142 ++++++++++++++
 tb/tb_systolic_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: controller state encoding and default mesh geometry.
// Pure declarations, no logic; latency and backpressure do not apply.
package npu_pkg;

  localparam int NPU_N  = 4;
  localparam int NPU_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/skew_line.sv
// DEPTH-stage zero-reset delay line; output lags input by DEPTH cycles.
// Always shifts: no stall or backpressure.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout
);

  logic [DW-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= i_din;
      for (int s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign o_dout = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN output-stationary systolic array: clear, skewed feed, zero drain, done.
// Run takes 3N+1 busy cycles; start is ignored while busy, no backpressure from the mesh.
module systolic_ctrl
  import npu_pkg::*;
#(
  parameter int N  = NPU_N,
  parameter int DW = NPU_DW,
  localparam int AW = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          array_clr,
  output logic          a_ren,
  output logic          b_ren,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  input  logic [N*DW-1:0] a_rdata,
  input  logic [N*DW-1:0] b_rdata,
  output logic [N*DW-1:0] west_data,
  output logic [N*DW-1:0] north_data
);

  localparam int CW = clog2_min1(2 * N);
  localparam logic [CW-1:0] FEED_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 2);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_ren_nxt;
  logic [AW-1:0]   w_addr_nxt;
  logic            r_busy, r_done, r_clr, r_ren;
  logic [AW-1:0]   r_addr;
  logic            w_feed;
  logic [N*DW-1:0] w_west_in, w_north_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ren_nxt   = 1'b0;
    w_addr_nxt  = '0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (start) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_state_nxt = ST_FEED;
        w_cnt_nxt   = '0;
      end
      ST_FEED: begin
        if (r_cnt == FEED_LAST) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Outputs are registered, so derive them from the state being entered.
    if (w_state_nxt == ST_CLEAR) begin
      w_ren_nxt = 1'b1;
    end else if (w_state_nxt == ST_FEED && w_cnt_nxt != FEED_LAST) begin
      w_ren_nxt  = 1'b1;
      w_addr_nxt = AW'(w_cnt_nxt + CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_clr  <= 1'b0;
      r_ren  <= 1'b0;
      r_addr <= '0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= (w_state_nxt == ST_DONE);
      r_clr  <= (w_state_nxt == ST_CLEAR);
      r_ren  <= w_ren_nxt;
      r_addr <= w_addr_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign array_clr = r_clr;
  assign a_ren     = r_ren;
  assign b_ren     = r_ren;
  assign a_addr    = r_addr;
  assign b_addr    = r_addr;

  // Read data arrives one cycle after the read, which is exactly the FEED window.
  assign w_feed     = (r_state == ST_FEED);
  assign w_west_in  = w_feed ? a_rdata : '0;
  assign w_north_in = w_feed ? b_rdata : '0;

  for (genvar l = 0; l < N; l++) begin : g_lane
    skew_line #(.DEPTH(l + 1), .DW(DW)) u_west (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_din  (w_west_in[l*DW +: DW]),
      .o_dout (west_data[l*DW +: DW])
    );
    skew_line #(.DEPTH(l + 1), .DW(DW)) u_north (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_din  (w_north_in[l*DW +: DW]),
      .o_dout (north_data[l*DW +: DW])
    );
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench: controller driving a behavioural 4x4 MAC mesh fed from two 1-cycle-latency buffers.
module tb_systolic_ctrl;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 2;
  localparam int RUN = 3 * N;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            busy, done, array_clr, a_ren, b_ren;
  logic [AW-1:0]   a_addr, b_addr;
  logic [N*DW-1:0] a_rdata = '0;
  logic [N*DW-1:0] b_rdata = '0;
  logic [N*DW-1:0] west_data, north_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] amat [N][N];
  logic [DW-1:0] bmat [N][N];
  logic [31:0]   acc  [N][N];
  logic [DW-1:0] wr   [N][N];
  logic [DW-1:0] nr   [N][N];

  systolic_ctrl #(.N(N), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .array_clr  (array_clr),
    .a_ren      (a_ren),
    .b_ren      (b_ren),
    .a_addr     (a_addr),
    .b_addr     (b_addr),
    .a_rdata    (a_rdata),
    .b_rdata    (b_rdata),
    .west_data  (west_data),
    .north_data (north_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Operand buffers: column k of A, row k of B, one cycle read latency.
  always @(posedge clk) begin
    if (a_ren) for (int i = 0; i < N; i++) a_rdata[i*DW +: DW] <= amat[i][a_addr];
    if (b_ren) for (int j = 0; j < N; j++) b_rdata[j*DW +: DW] <= bmat[b_addr][j];
  end

  function automatic logic [DW-1:0] pe_w(input int i, input int j);
    if (j == 0) return west_data[i*DW +: DW];
    else        return wr[i][j-1];
  endfunction

  function automatic logic [DW-1:0] pe_n(input int i, input int j);
    if (i == 0) return north_data[j*DW +: DW];
    else        return nr[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (array_clr) begin
          acc[i][j] <= '0;
          wr[i][j]  <= '0;
          nr[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + 32'(pe_w(i, j)) * 32'(pe_n(i, j));
          wr[i][j]  <= pe_w(i, j);
          nr[i][j]  <= pe_n(i, j);
        end
      end
    end
  end

  function automatic logic [31:0] ref_c(input int i, input int j);
    logic [31:0] s = '0;
    for (int k = 0; k < N; k++) s += 32'(amat[i][k]) * 32'(bmat[k][j]);
    return s;
  endfunction

  // Edge lane contents by cycle: element k reaches lane l in cycle k+2+l.
  function automatic logic [N*DW-1:0] exp_west(input int c);
    logic [N*DW-1:0] v = '0;
    for (int i = 0; i < N; i++) begin
      int k = c - 2 - i;
      if (k >= 0 && k < N) v[i*DW +: DW] = amat[i][k];
    end
    return v;
  endfunction

  function automatic logic [N*DW-1:0] exp_north(input int c);
    logic [N*DW-1:0] v = '0;
    for (int j = 0; j < N; j++) begin
      int k = c - 2 - j;
      if (k >= 0 && k < N) v[j*DW +: DW] = bmat[k][j];
    end
    return v;
  endfunction

  task automatic load(input int mode);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        case (mode)
          0: begin amat[i][j] = 8'd1; bmat[i][j] = 8'd2; end
          1: begin amat[i][j] = (i == j) ? 8'd1 : 8'd0; bmat[i][j] = 8'(i * N + j + 1); end
          2: begin amat[i][j] = 8'd255; bmat[i][j] = 8'd255; end
          default: begin amat[i][j] = 8'($urandom); bmat[i][j] = 8'($urandom); end
        endcase
      end
    end
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s res[%0d][%0d]", tag, i, j), acc[i][j], ref_c(i, j));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " clr"}, array_clr, 1'b0);
    chk({tag, " ren"}, {a_ren, b_ren}, 2'b00);
    chk({tag, " addr"}, {a_addr, b_addr}, '0);
    chk({tag, " west"}, west_data, '0);
    chk({tag, " north"}, north_data, '0);
  endtask

  task automatic do_run(input string tag, input bit noise);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= RUN + 1; c++) begin
      @(negedge clk);
      chk($sformatf("%s busy c%0d", tag, c), busy, c <= RUN);
      chk($sformatf("%s done c%0d", tag, c), done, c == RUN);
      chk($sformatf("%s clr c%0d", tag, c), array_clr, c == 0);
      chk($sformatf("%s aren c%0d", tag, c), a_ren, c < N);
      chk($sformatf("%s bren c%0d", tag, c), b_ren, c < N);
      if (c < N) begin
        chk($sformatf("%s aaddr c%0d", tag, c), a_addr, c);
        chk($sformatf("%s baddr c%0d", tag, c), b_addr, c);
      end
      chk($sformatf("%s west c%0d", tag, c), west_data, exp_west(c));
      chk($sformatf("%s north c%0d", tag, c), north_data, exp_north(c));
      if (c == RUN) check_results(tag);
      start = (noise && c <= RUN) ? 1'($urandom) : 1'b0;
    end
  endtask

  initial begin
    // Reset and idle
    load(0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_idle_outputs($sformatf("idle c%0d", c));
    end

    load(0); do_run("ones", 1'b0);
    load(1); do_run("ident", 1'b0);
    load(2); do_run("max", 1'b0);
    for (int r = 0; r < 4; r++) begin
      load(3);
      do_run($sformatf("rand%0d", r), 1'b1);
    end

    // Start held high: back-to-back runs every 3N+2 cycles
    load(3);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 2 * (RUN + 2); c++) begin
      @(negedge clk);
      chk($sformatf("held clr c%0d", c), array_clr, (c % (RUN + 2)) == 0);
      chk($sformatf("held done c%0d", c), done, (c % (RUN + 2)) == RUN);
      chk($sformatf("held busy c%0d", c), busy, (c % (RUN + 2)) <= RUN);
      if (c == 2 * (RUN + 2) - 2) check_results("held run2");
      if (c == 2 * (RUN + 2) - 1) start = 1'b0;
    end
    repeat (2) @(negedge clk);

    // Reset in the middle of a run
    load(3);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("midrst done c%0d", c), done, 1'b0);
      chk($sformatf("midrst busy c%0d", c), busy, 1'b0);
    end
    rst_n = 1'b1;
    load(0);
    do_run("post_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
